// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operation request and result/HI/LO bundle for alu_exec_unit.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             valid_in;
    logic             ready;
    logic [1:0]       ALUop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output valid_in, ALUop, funct, a, b,
                    input  ready, valid_out, result, zero, illegal, hi, lo);
    modport slave  (input  valid_in, ALUop, funct, a, b,
                    output ready, valid_out, result, zero, illegal, hi, lo);
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU plus WIDTH-step shift-add multu; divu (restoring)
// exists only when ALU_DIVIDER_EN is defined, otherwise funct 011011 is illegal.
module alu_exec_unit #(parameter int WIDTH = 32) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);
`ifdef ALU_DIVIDER_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_result, r_hi, r_lo, r_m, r_cnt, w_res, w_sm;
    logic [2*WIDTH-1:0] r_p, w_sp, w_np;
    logic               r_valid, r_zero, r_illegal;
    logic               w_ill, w_mul, w_div, w_acc, w_start, w_last;

    // {upper, multiplier}: add multiplicand on LSB, then shift right with carry
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {s, p[WIDTH-1:1]};
    endfunction

`ifdef ALU_DIVIDER_EN
    // {remainder, dividend/quotient}: shift left, subtract when it fits; d=0 yields q=all ones, r=a
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] d);
        logic [WIDTH:0] u;
        u = p[2*WIDTH-1:WIDTH-1];
        return (u >= {1'b0, d}) ? {u[WIDTH-1:0] - d, p[WIDTH-2:0], 1'b1} : {u[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    endfunction
`endif

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        w_mul = 1'b0;
        w_div = 1'b0;
        case (bus.ALUop)
            2'b00: w_res = bus.a + bus.b;
            2'b01: w_res = bus.a - bus.b;
            2'b11: w_res = bus.a & bus.b;
            default: case (bus.funct)
                6'b100000, 6'b100001: w_res = bus.a + bus.b;
                6'b100010, 6'b100011: w_res = bus.a - bus.b;
                6'b100100: w_res = bus.a & bus.b;
                6'b100101: w_res = bus.a | bus.b;
                6'b100110: w_res = bus.a ^ bus.b;
                6'b100111: w_res = ~(bus.a | bus.b);
                6'b101010: w_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
                6'b101011: w_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                6'b011001: w_mul = 1'b1;
`ifdef ALU_DIVIDER_EN
                6'b011011: w_div = 1'b1;
`endif
                6'b010000: w_res = r_hi;
                6'b010010: w_res = r_lo;
                default:   w_ill = 1'b1;
            endcase
        endcase
    end

    assign bus.ready     = r_state == S_IDLE;
    assign bus.valid_out = r_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign w_acc   = bus.valid_in && bus.ready;
    assign w_start = w_acc && (w_mul || w_div);
    assign w_last  = r_cnt == WIDTH'(1);
    // first iteration runs on the accept edge straight from the operands
    assign w_sp = w_start ? {{WIDTH{1'b0}}, w_div ? bus.a : bus.b} : r_p;
    assign w_sm = w_start ? (w_div ? bus.b : bus.a) : r_m;
`ifdef ALU_DIVIDER_EN
    assign w_np = (w_start ? w_div : r_state == S_DIV) ? div_step(w_sp, w_sm) : mul_step(w_sp, w_sm);
`else
    assign w_np = mul_step(w_sp, w_sm);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = S_MUL;
        else if (w_last) w_next = S_IDLE;
`ifdef ALU_DIVIDER_EN
        if (w_start && w_div) w_next = S_DIV;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_p       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_acc && !w_start) begin
                r_valid   <= 1'b1;
                r_result  <= w_res;
                r_zero    <= w_res == '0;
                r_illegal <= w_ill;
            end
            if (w_start || r_state != S_IDLE) r_p <= w_np;
            if (w_start) begin
                r_m   <= w_sm;
                r_cnt <= WIDTH'(WIDTH-1);
            end else if (r_state != S_IDLE) r_cnt <= r_cnt - WIDTH'(1);
            if (w_last) begin
                r_valid   <= 1'b1;
                r_result  <= w_np[WIDTH-1:0];
                r_zero    <= w_np[WIDTH-1:0] == '0;
                r_illegal <= 1'b0;
                r_hi      <= w_np[2*WIDTH-1:WIDTH];
                r_lo      <= w_np[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit, checked each cycle against
// an arithmetic model plus hand-computed literals.
module tb_alu_exec_unit;
    localparam int W = 32;
    localparam logic [1:0] K_ONE = 2'd0, K_MUL = 2'd1, K_DIV = 2'd2;
    typedef struct packed { logic [1:0] kind; logic [W-1:0] res; logic ill; } dec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.WIDTH(W)) bus();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic dec_t model_op(input logic [1:0] o, input logic [5:0] f, input logic [W-1:0] x, y, h, l);
        dec_t d;
        d = '0;
        if (o == 2'b00) d.res = x + y;
        else if (o == 2'b01) d.res = x - y;
        else if (o == 2'b11) d.res = x & y;
        else case (f)
            6'b100000, 6'b100001: d.res = x + y;
            6'b100010, 6'b100011: d.res = x - y;
            6'b100100: d.res = x & y;
            6'b100101: d.res = x | y;
            6'b100110: d.res = x ^ y;
            6'b100111: d.res = ~(x | y);
            6'b101010: d.res = ($signed(x) < $signed(y)) ? 1 : 0;
            6'b101011: d.res = (x < y) ? 1 : 0;
            6'b011001: d.kind = K_MUL;
            6'b011011: begin
`ifdef ALU_DIVIDER_EN
                d.kind = K_DIV;
`else
                d.ill = 1'b1;
`endif
            end
            6'b010000: d.res = h;
            6'b010010: d.res = l;
            default:   d.ill = 1'b1;
        endcase
        return d;
    endfunction

    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, e_res = '0;
    logic         e_vo = 1'b0, e_zero = 1'b1, e_ill = 1'b0;
    dec_t         md;
    assign md = model_op(bus.ALUop, bus.funct, bus.a, bus.b, m_hi, m_lo);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi <= '0;
            m_lo <= '0;
            e_vo <= 1'b0;
            e_res <= '0;
            e_zero <= 1'b1;
            e_ill <= 1'b0;
        end else begin
            e_vo <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    e_vo <= 1'b1;
                    m_hi <= p_hi;
                    m_lo <= p_lo;
                    e_res <= p_lo;
                    e_zero <= p_lo == 0;
                    e_ill <= 1'b0;
                end
            end else if (bus.valid_in) begin
                if (md.kind == K_ONE) begin
                    e_vo <= 1'b1;
                    e_res <= md.res;
                    e_zero <= md.res == 0;
                    e_ill <= md.ill;
                end else begin
                    m_left <= W - 1;
                    if (md.kind == K_MUL) {p_hi, p_lo} <= {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
                    else if (bus.b == 0) {p_hi, p_lo} <= {bus.a, {W{1'b1}}};
                    else {p_hi, p_lo} <= {bus.a % bus.b, bus.a / bus.b};
                end
            end
        end
    end

    always @(negedge clk) if (!reset) begin
        chk("ready", bus.ready, m_left == 0);
        chk("valid_out", bus.valid_out, e_vo);
        chk("result", bus.result, e_res);
        chk("zero", bus.zero, e_zero);
        chk("illegal", bus.illegal, e_ill);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    end

    task automatic op(input logic [1:0] o, input logic [5:0] f, input logic [W-1:0] x, y);
        int n = 0;
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.ALUop = o;
        bus.funct = f;
        bus.a = x;
        bus.b = y;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.ALUop = 2'b00;
        bus.funct = 6'd0;
        bus.a = 32'hDEADBEEF;
        bus.b = 32'h0BADF00D;
    endtask

    task automatic wait_vo(output int lat, output int busy);
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.ready) busy++;
        end while (!bus.valid_out && lat < 100);
    endtask

    task automatic one(input string n, input logic [1:0] o, input logic [5:0] f, input logic [W-1:0] x, y, r);
        op(o, f, x, y);
        @(negedge clk);
        chk({n, "_vo"}, bus.valid_out, 1'b1);
        chk(n, bus.result, r);
    endtask

    initial begin
        int lat, busy, pulses;
        bus.valid_in = 1'b0;
        bus.ALUop = 2'b00;
        bus.funct = 6'd0;
        bus.a = '0;
        bus.b = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_vo", bus.valid_out, 1'b0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1'b1);
        chk("rst_illegal", bus.illegal, 1'b0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        one("slt_neg", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h1);
        one("sltu_big", 2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 32'h0);
        chk("sltu_zero", bus.zero, 1'b1);
        one("add00", 2'b00, 6'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
        one("sub01", 2'b01, 6'd0, 32'h0, 32'h1, 32'hFFFFFFFF);
        one("and11", 2'b11, 6'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        one("addu_wrap", 2'b10, 6'b100001, 32'hFFFFFFFF, 32'h1, 32'h0);
        chk("addu_wrap_zero", bus.zero, 1'b1);
        one("add", 2'b10, 6'b100000, 32'h1, 32'h2, 32'h3);
        one("subu", 2'b10, 6'b100011, 32'h5, 32'h7, 32'hFFFFFFFE);
        one("and", 2'b10, 6'b100100, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00);
        one("or", 2'b10, 6'b100101, 32'hF0000000, 32'h0000000F, 32'hF000000F);
        one("xor", 2'b10, 6'b100110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00);
        one("nor", 2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F);
        one("slt_pos", 2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF, 32'h0);
        one("slt_min", 2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'h1);
        one("sltu_small", 2'b10, 6'b101011, 32'h1, 32'hFFFFFFFF, 32'h1);

        op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'h2);
        wait_vo(lat, busy);
        chk("mul_latency", 64'(lat), 64'd32);
        chk("mul_busy", 64'(busy), 64'd31);
        chk("mul_hi", bus.hi, 32'h1);
        chk("mul_lo", bus.lo, 32'hFFFFFFFE);
        chk("mul_result", bus.result, 32'hFFFFFFFE);

        one("illegal_res", 2'b10, 6'b111111, 32'h5, 32'h6, 32'h0);
        chk("illegal_flag", bus.illegal, 1'b1);
        chk("illegal_zero", bus.zero, 1'b1);
        chk("illegal_hi", bus.hi, 32'h1);
        chk("illegal_lo", bus.lo, 32'hFFFFFFFE);
        one("mfhi", 2'b10, 6'b010000, 32'h0, 32'h0, 32'h1);
        one("mflo", 2'b10, 6'b010010, 32'h0, 32'h0, 32'hFFFFFFFE);

        op(2'b10, 6'b011001, 32'h00010001, 32'h00010000);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.ALUop = 2'b00;
        bus.a = 32'h1;
        bus.b = 32'h1;
        repeat (20) @(negedge clk);
        bus.valid_in = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_out) pulses++;
        end
        chk("held_valid_pulses", 64'(pulses), 64'd1);
        chk("mul2_hi", bus.hi, 32'h1);
        chk("mul2_lo", bus.lo, 32'h00010000);

        op(2'b10, 6'b011001, 32'h3, 32'h5);
        op(2'b00, 6'd0, 32'h11, 32'h22);
        @(negedge clk);
        chk("b2b_vo", bus.valid_out, 1'b1);
        chk("b2b_result", bus.result, 32'h33);
        chk("b2b_lo", bus.lo, 32'hF);

`ifdef ALU_DIVIDER_EN
        op(2'b10, 6'b011011, 32'h7, 32'h2);
        wait_vo(lat, busy);
        chk("div_latency", 64'(lat), 64'd32);
        chk("div_lo", bus.lo, 32'h3);
        chk("div_hi", bus.hi, 32'h1);
        op(2'b10, 6'b011011, 32'h5, 32'h0);
        wait_vo(lat, busy);
        chk("div0_lo", bus.lo, 32'hFFFFFFFF);
        chk("div0_hi", bus.hi, 32'h5);
        chk("div0_illegal", bus.illegal, 1'b0);
        one("mfhi_div", 2'b10, 6'b010000, 32'h0, 32'h0, 32'h5);
`else
        op(2'b10, 6'b011011, 32'h7, 32'h2);
        @(negedge clk);
        chk("nodiv_vo", bus.valid_out, 1'b1);
        chk("nodiv_illegal", bus.illegal, 1'b1);
        chk("nodiv_result", bus.result, 32'h0);
        chk("nodiv_hi", bus.hi, 32'h0);
        chk("nodiv_lo", bus.lo, 32'hF);
`endif

        op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", bus.ready, 1'b1);
        chk("midrst_vo", bus.valid_out, 1'b0);
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_zero", bus.zero, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_out) pulses++;
        end
        chk("post_reset_pulses", 64'(pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
